// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit (0), WIDTH data bits LSB first,
// stop bit (1), each bit held for BAUD_DIV clocks. All outputs are registered.
module serial_tx #(
    parameter int WIDTH    = 8,
    parameter int BAUD_DIV = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             busy,
    output logic             tx,
    output logic             done
);

    localparam int BW = $clog2(BAUD_DIV) + 1;
    localparam int IW = $clog2(WIDTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             busy_q;
    logic             bit_end;
    logic [WIDTH-1:0] shift_nxt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            shift_q <= '0;
            baud_q  <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= ~ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        baud_d    = baud_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        bit_end   = (baud_q == BAUD_LAST);
        shift_nxt = shift_q >> 1;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                idx_d  = '0;
                tx_d   = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_nxt;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                        tx_d  = shift_nxt[0];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // ready is already high in the last stop cycle, so a start sampled on the
        // frame-ending edge chains the next start bit with no idle gap.
        if (start && ready_q) begin
            state_d = START;
            shift_d = din;
            baud_d  = '0;
            idx_d   = '0;
            tx_d    = 1'b0;
        end

        ready_d = (state_d == IDLE) || ((state_d == STOP) && (baud_d == BAUD_LAST));
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign tx    = tx_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: an 8-bit/4-clk instance and a 4-bit/1-clk instance,
// each with a queue-fed monitor comparing every frame cycle and every done pulse.
module tb_serial_tx;

    typedef struct {
        logic [7:0] w;
        int         t;
    } frame_t;

    logic       clk = 1'b0;
    logic       clr;
    logic       start_a, start_b;
    logic [7:0] din_a;
    logic [3:0] din_b;
    logic       ready_a, busy_a, tx_a, done_a;
    logic       ready_b, busy_b, tx_b, done_b;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    frame_t qa[$];
    logic   qb[$];
    int     done_times[$];
    bit     act_a = 1'b0;
    bit     act_b = 1'b0;

    serial_tx #(.WIDTH(8), .BAUD_DIV(4)) dut_a (
        .clk(clk), .clr(clr), .start(start_a), .din(din_a),
        .ready(ready_a), .busy(busy_a), .tx(tx_a), .done(done_a)
    );

    serial_tx #(.WIDTH(4), .BAUD_DIV(1)) dut_b (
        .clk(clk), .clr(clr), .start(start_b), .din(din_b),
        .ready(ready_b), .busy(busy_b), .tx(tx_b), .done(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic checki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor for the 8-bit instance: frame model indexed by bit slot.
    initial begin : mon_a
        frame_t cur;
        int     pos   = 0;
        int     due   = -1;
        int     bi;
        logic   eb;
        logic   exp_d;
        cur = '{8'h00, 0};
        forever begin
            @(negedge clk);
            if (clr) begin
                act_a = 1'b0;
                due   = -1;
            end else begin
                exp_d = (cyc == due);
                if (done_a || exp_d) check1("done_a", done_a, exp_d);
                if (done_a) done_times.push_back(cyc);
                check1("busy_vs_ready_a", busy_a, ~ready_a);
                if (!act_a && tx_a == 1'b0) begin
                    if (qa.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_frame_a: start bit seen with empty queue (cycle %0d)", cyc);
                        cur = '{8'h00, cyc};
                    end else begin
                        cur = qa.pop_front();
                        checki("frame_start_cycle_a", cyc, cur.t);
                    end
                    act_a = 1'b1;
                    pos   = 0;
                end
                if (act_a) begin
                    bi = pos / 4;
                    if (bi == 0)      eb = 1'b0;
                    else if (bi <= 8) eb = cur.w[bi-1];
                    else              eb = 1'b1;
                    check1("tx_a", tx_a, eb);
                    pos++;
                    if (pos == 40) begin
                        act_a = 1'b0;
                        due   = cyc + 1;
                    end
                end
            end
        end
    end

    // Monitor for the 4-bit instance: hand-written per-cycle tx vectors.
    initial begin : mon_b
        int   due = -1;
        logic eb;
        logic exp_d;
        forever begin
            @(negedge clk);
            if (clr) begin
                act_b = 1'b0;
                due   = -1;
            end else begin
                exp_d = (cyc == due);
                if (done_b || exp_d) check1("done_b", done_b, exp_d);
                check1("busy_vs_ready_b", busy_b, ~ready_b);
                if (!act_b && tx_b == 1'b0) begin
                    if (qb.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_frame_b: start bit seen with empty queue (cycle %0d)", cyc);
                    end else begin
                        act_b = 1'b1;
                    end
                end
                if (act_b) begin
                    eb = qb.pop_front();
                    check1("tx_b", tx_b, eb);
                    if (qb.size() == 0) begin
                        act_b = 1'b0;
                        due   = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic send_a(input logic [7:0] w);
        int n = 0;
        while (!ready_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        checki("send_a_ready_timeout", int'(ready_a), 1);
        din_a   = w;
        start_a = 1'b1;
        qa.push_back('{w, cyc + 1});
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while ((qa.size() != 0 || act_a) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checki("wait_idle_a_timeout", int'(qa.size() != 0 || act_a), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle_b();
        int n = 0;
        while ((qb.size() != 0 || act_b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checki("wait_idle_b_timeout", int'(qb.size() != 0 || act_b), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0;
        clr     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        din_a   = '0;
        din_b   = '0;

        // Reset state, before any clock edge
        #1;
        check1("rst_tx_a", tx_a, 1'b1);
        check1("rst_ready_a", ready_a, 1'b1);
        check1("rst_busy_a", busy_a, 1'b0);
        check1("rst_done_a", done_a, 1'b0);
        check1("rst_tx_b", tx_b, 1'b1);
        check1("rst_ready_b", ready_b, 1'b1);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame A5
        send_a(8'hA5);
        wait_idle_a();

        // Back-to-back with start held high: 01 then FF
        n0      = done_times.size();
        din_a   = 8'h01;
        start_a = 1'b1;
        qa.push_back('{8'h01, cyc + 1});
        qa.push_back('{8'hFF, cyc + 41});
        @(negedge clk);
        din_a = 8'hFF;
        repeat (40) @(negedge clk);
        start_a = 1'b0;
        din_a   = 8'h00;
        wait_idle_a();
        checki("b2b_done_count", done_times.size() - n0, 2);
        if (done_times.size() - n0 == 2)
            checki("b2b_done_spacing", done_times[n0+1] - done_times[n0], 40);

        // Start and new din pulsed mid-frame are ignored
        send_a(8'h5A);
        repeat (10) @(negedge clk);
        start_a = 1'b1;
        din_a   = 8'h3C;
        @(negedge clk);
        start_a = 1'b0;
        din_a   = 8'h5A;
        repeat (27) @(negedge clk);
        check1("busy_late_frame", busy_a, 1'b1);
        repeat (2) @(negedge clk);
        check1("busy_after_frame", busy_a, 1'b0);
        repeat (60) @(negedge clk);
        check1("idle_tx_after_ignore", tx_a, 1'b1);
        check1("idle_ready_after_ignore", ready_a, 1'b1);
        checki("no_queued_frame", qa.size(), 0);

        // Asynchronous reset during data bit 3
        send_a(8'h96);
        repeat (16) @(negedge clk);
        @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        check1("midrst_tx", tx_a, 1'b1);
        check1("midrst_ready", ready_a, 1'b1);
        check1("midrst_busy", busy_a, 1'b0);
        check1("midrst_done", done_a, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2;
        clr = 1'b0;
        @(negedge clk);
        repeat (50) @(negedge clk);
        check1("no_resume_tx", tx_a, 1'b1);
        send_a(8'hC3);
        wait_idle_a();

        // WIDTH=4, BAUD_DIV=1: 1001 -> 0,1,0,0,1,1 ; 0110 -> 0,0,1,1,0,1
        din_b   = 4'b1001;
        start_b = 1'b1;
        qb.push_back(1'b0); qb.push_back(1'b1); qb.push_back(1'b0);
        qb.push_back(1'b0); qb.push_back(1'b1); qb.push_back(1'b1);
        @(negedge clk);
        start_b = 1'b0;
        wait_idle_b();
        din_b   = 4'b0110;
        start_b = 1'b1;
        qb.push_back(1'b0); qb.push_back(1'b0); qb.push_back(1'b1);
        qb.push_back(1'b1); qb.push_back(1'b0); qb.push_back(1'b1);
        @(negedge clk);
        start_b = 1'b0;
        wait_idle_b();
        check1("b_idle_tx", tx_b, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
